// File: rtl/pwm_wave_sched_pkg.sv
// pwm_wave_sched_pkg: register addresses, CTRL bit positions and sequencer states
package pwm_wave_sched_pkg;
  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_DIV = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_LEN = 3'd3;
  localparam logic [2:0] A_IDX = 3'd4;
  localparam logic [2:0] A_DATA = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_IRQ = 3'd7;
  localparam int CTRL_RUN = 0;
  localparam int CTRL_LOOP = 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;
endpackage

// File: rtl/pwm_wave_sched_if.sv
// pwm_wave_sched_if: Avalon-MM register bus with zero-wait-state combinational reads
interface pwm_wave_sched_if;
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one tick every 2^div_sel cycles, held at the start of an interval by clear
module pwm_prescaler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] div_sel,
  input  logic       clear,
  output logic       tick
);
  logic [6:0] pre_q, pre_d;
  always_comb begin
    tick = !clear && pre_q == 7'((8'd1 << div_sel) - 8'd1);
    pre_d = (clear || tick) ? '0 : pre_q + 7'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pre_q <= '0;
    else pre_q <= pre_d;
endmodule

// File: rtl/pwm_wave_sched.sv
// pwm_wave_sched: duty-table PWM sequencer on Avalon-MM; PWM_WAVE_SCHED_IRQ_EN adds a completion irq
module pwm_wave_sched import pwm_wave_sched_pkg::*; #(
  parameter int TBL_DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pwm_wave_sched_if.slave        bus,
  output logic [2:0]             div_sel,
  output logic                   pwm_out,
  output logic                   busy,
  output logic                   step_pulse
`ifdef PWM_WAVE_SCHED_IRQ_EN
  ,
  output logic                   irq
`endif
);
  localparam int IW = $clog2(TBL_DEPTH);
  state_e state_q, state_d;
  logic run_q, run_d, loop_q, loop_d, pwm_q, pwm_d;
  logic [2:0] div_q, div_d, sdiv_q, sdiv_d;
  logic [CNT_W-1:0] period_q, period_d, speriod_q, speriod_d, cnt_q, cnt_d;
  logic [IW-1:0] len_q, len_d, idx_q, idx_d, step_q, step_d;
  logic [CNT_W-1:0] duty_q [TBL_DEPTH];
  logic [CNT_W-1:0] duty_d [TBL_DEPTH];
  logic wr, stop, tick, wrap, unused_wd;
  logic [1:0] irq_rd;

  pwm_prescaler u_pre (.clk(clk), .reset_n(reset_n), .div_sel(sdiv_q), .clear(state_q != S_RUN), .tick(tick));

  assign wr = bus.chipselect && !bus.write_n;
  assign stop = wr && bus.address == A_CTRL && !bus.writedata[CTRL_RUN];
  // a stop write in the same cycle as a wrap suppresses the period end entirely
  assign wrap = state_q == S_RUN && tick && cnt_q == speriod_q && !stop;
  assign unused_wd = ^bus.writedata;
  assign step_pulse = wrap;
  assign busy = state_q != S_IDLE;
  assign div_sel = sdiv_q;
  assign pwm_out = pwm_q;

  always_comb begin
    state_d = state_q;
    run_d = run_q;
    loop_d = loop_q;
    div_d = div_q;
    period_d = period_q;
    len_d = len_q;
    idx_d = idx_q;
    duty_d = duty_q;
    sdiv_d = sdiv_q;
    speriod_d = speriod_q;
    step_d = step_q;
    cnt_d = cnt_q;
    if (wr) begin
      if (bus.address == A_CTRL) loop_d = bus.writedata[CTRL_LOOP];
      if (bus.address == A_DIV) div_d = bus.writedata[2:0];
      if (bus.address == A_PERIOD) period_d = bus.writedata[CNT_W-1:0];
      if (bus.address == A_LEN) len_d = bus.writedata[IW-1:0];
      if (bus.address == A_IDX) idx_d = bus.writedata[IW-1:0];
      if (bus.address == A_DATA) begin
        duty_d[idx_q] = bus.writedata[CNT_W-1:0];
        idx_d = idx_q + IW'(1);
      end
    end
    if (stop) begin
      state_d = S_IDLE;
      run_d = 1'b0;
    end else if (state_q == S_IDLE && wr && bus.address == A_CTRL) begin
      state_d = S_LOAD;
      run_d = 1'b1;
    end else if (state_q == S_LOAD) begin
      state_d = S_RUN;
      sdiv_d = div_q;
      speriod_d = period_q;
      step_d = '0;
      cnt_d = '0;
    end else if (state_q == S_RUN && tick) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        sdiv_d = div_q;
        speriod_d = period_q;
        step_d = (step_q == len_q) ? '0 : step_q + IW'(1);
        if (step_q == len_q && !loop_q) begin
          state_d = S_IDLE;
          run_d = 1'b0;
        end
      end
    end
    pwm_d = state_d == S_RUN && cnt_d < duty_d[step_d];
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q <= 1'b0;
      loop_q <= 1'b0;
      pwm_q <= 1'b0;
      div_q <= '0;
      sdiv_q <= '0;
      period_q <= '0;
      speriod_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      step_q <= '0;
      duty_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      loop_q <= loop_d;
      pwm_q <= pwm_d;
      div_q <= div_d;
      sdiv_q <= sdiv_d;
      period_q <= period_d;
      speriod_q <= speriod_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      idx_q <= idx_d;
      step_q <= step_d;
      duty_q <= duty_d;
    end

`ifdef PWM_WAVE_SCHED_IRQ_EN
  logic pend_q, pend_d, irq_en_q, irq_en_d;
  always_comb begin
    irq_en_d = (wr && bus.address == A_IRQ) ? bus.writedata[1] : irq_en_q;
    pend_d = (wrap && state_d == S_IDLE) || (pend_q && !(wr && bus.address == A_IRQ && bus.writedata[0]));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_en_q <= irq_en_d;
    end
  assign irq = pend_q && irq_en_q;
  assign irq_rd = {irq_en_q, pend_q};
`else
  assign irq_rd = 2'b00;
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      A_CTRL: bus.readdata = {30'd0, loop_q, run_q};
      A_DIV: bus.readdata = {29'd0, div_q};
      A_PERIOD: bus.readdata = 32'(period_q);
      A_LEN: bus.readdata = 32'(len_q);
      A_IDX: bus.readdata = 32'(idx_q);
      A_DATA: bus.readdata = 32'(duty_q[idx_q]);
      A_STATUS: bus.readdata = {24'd0, 4'(step_q), 3'd0, busy};
      A_IRQ: bus.readdata = {30'd0, irq_rd};
    endcase
  end
endmodule

// File: tb/tb_pwm_wave_sched.sv
// tb_pwm_wave_sched: register vectors, directed corner sequences and randomized runs against a waveform model
module tb_pwm_wave_sched;
  import pwm_wave_sched_pkg::*;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] div_sel;
  logic pwm_out, busy, step_pulse;
`ifdef PWM_WAVE_SCHED_IRQ_EN
  logic irq;
`endif
  int errs = 0;
  int checks = 0;
  int duty_m [8];

  pwm_wave_sched_if bus ();

  pwm_wave_sched #(.TBL_DEPTH(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .div_sel(div_sel),
    .pwm_out(pwm_out),
    .busy(busy),
    .step_pulse(step_pulse)
`ifdef PWM_WAVE_SCHED_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    step1();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step1();
    step1();
    reset_n = 1'b1;
    step1();
  endtask

  // Expected waveform built from the period/step rules: each step is PERIOD+1 counts of 2^DIV cycles.
  task automatic run_seq(input int dv, input int pr, input int ln, output int highs);
    bit exp_pwm[$];
    bit exp_sp[$];
    logic [31:0] d;
    wr(A_DIV, 32'(dv));
    wr(A_PERIOD, 32'(pr));
    wr(A_LEN, 32'(ln));
    wr(A_IDX, 32'd0);
    for (int s = 0; s <= ln; s++) wr(A_DATA, 32'(duty_m[s]));
    for (int s = 0; s <= ln; s++)
      for (int c = 0; c <= pr; c++)
        for (int t = 0; t < (1 << dv); t++) begin
          exp_pwm.push_back(c < duty_m[s]);
          exp_sp.push_back(c == pr && t == (1 << dv) - 1);
        end
    wr(A_CTRL, 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    highs = 0;
    foreach (exp_pwm[i]) begin
      step1();
      chk("seq_pwm", 32'(pwm_out), 32'(exp_pwm[i]));
      chk("seq_pulse", 32'(step_pulse), 32'(exp_sp[i]));
      chk("seq_busy", 32'(busy), 32'd1);
      if (pwm_out) highs++;
    end
    step1();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_pwm", 32'(pwm_out), 32'd0);
    rd(A_CTRL, d);
    chk("end_run", d, 32'd0);
  endtask

  initial begin
    vec_t v[8];
    logic [31:0] d;
    int h;
    int n;
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    v[0] = '{A_DIV, 32'hFFFF_FFFF, 32'h7};
    v[1] = '{A_PERIOD, 32'hFFFF_FF5A, 32'h5A};
    v[2] = '{A_LEN, 32'hFFFF_FFFD, 32'h5};
    v[3] = '{A_IDX, 32'h0000_000B, 32'h3};
    v[4] = '{A_CTRL, 32'hFFFF_FFF2, 32'h2};
    v[5] = '{A_STATUS, 32'hFFFF_FFFF, 32'h0};
`ifdef PWM_WAVE_SCHED_IRQ_EN
    v[6] = '{A_IRQ, 32'hFFFF_FFFE, 32'h2};
`else
    v[6] = '{A_IRQ, 32'hFFFF_FFFE, 32'h0};
`endif
    v[7] = '{A_CTRL, 32'h0, 32'h0};

    #2;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    chk("rst_div_sel", 32'(div_sel), 32'd0);
    step1();
    reset_n = 1'b1;
    step1();

    foreach (v[i]) begin
      wr(v[i].a, v[i].wd);
      rd(v[i].a, d);
      chk($sformatf("reg_addr%0d", v[i].a), d, v[i].exp);
    end

    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 32'd0);
      step1();
    end

    // table pointer wraps from 7 to 0
    wr(A_IDX, 32'd7);
    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    rd(A_IDX, d);
    chk("idx_wrap", d, 32'd1);
    wr(A_IDX, 32'd7);
    rd(A_DATA, d);
    chk("duty7", d, 32'h11);
    wr(A_IDX, 32'd0);
    rd(A_DATA, d);
    chk("duty0", d, 32'h22);

    // DIV=0 PERIOD=3 duty 2 looping, then a stop write while high
    wr(A_DIV, 32'd0);
    wr(A_PERIOD, 32'd3);
    wr(A_LEN, 32'd0);
    wr(A_IDX, 32'd0);
    wr(A_DATA, 32'd2);
    wr(A_CTRL, 32'd3);
    chk("p1_load_busy", 32'(busy), 32'd1);
    chk("p1_load_pwm", 32'(pwm_out), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step1();
      chk($sformatf("p1_pwm_k%0d", k), 32'(pwm_out), 32'((k % 4) < 2));
      chk($sformatf("p1_pulse_k%0d", k), 32'(step_pulse), 32'((k % 4) == 3));
    end
    step1();
    step1();
    chk("stop_pre_pwm", 32'(pwm_out), 32'd1);
    wr(A_CTRL, 32'd0);
    chk("stop_pwm", 32'(pwm_out), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_pulse", 32'(step_pulse), 32'd0);

    // DIV=2 PERIOD=1 three steps {0,1,2}, no loop
    duty_m[0] = 0;
    duty_m[1] = 1;
    duty_m[2] = 2;
    run_seq(2, 1, 2, h);
    chk("p2_high_cycles", 32'(h), 32'd12);

    // DIV change mid-period only reaches div_sel after the period ends
    wr(A_DIV, 32'd0);
    wr(A_PERIOD, 32'd9);
    wr(A_LEN, 32'd0);
    wr(A_IDX, 32'd0);
    wr(A_DATA, 32'd5);
    wr(A_CTRL, 32'd3);
    step1();
    step1();
    step1();
    wr(A_DIV, 32'd3);
    n = 0;
    while (!step_pulse && n < 20) begin
      chk("div_hold", 32'(div_sel), 32'd0);
      step1();
      n++;
    end
    chk("div_pulse_seen", 32'(step_pulse), 32'd1);
    chk("div_at_pulse", 32'(div_sel), 32'd0);
    step1();
    chk("div_after", 32'(div_sel), 32'd3);

    // run=1 while busy only clears loop: sequence ends at this period's end, no restart
    wr(A_CTRL, 32'd1);
    rd(A_CTRL, d);
    chk("busy_ctrl", d, 32'd1);
    chk("busy_still", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 400) begin
      step1();
      n++;
    end
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("no_restart_len", 32'(n), 32'd79);

`ifdef PWM_WAVE_SCHED_IRQ_EN
    wr(A_IRQ, 32'd3);
    chk("irq_idle", 32'(irq), 32'd0);
    duty_m[0] = 1;
    run_seq(0, 1, 0, h);
    chk("irq_set", 32'(irq), 32'd1);
    rd(A_IRQ, d);
    chk("irq_reg", d, 32'd3);
    wr(A_IRQ, 32'd3);
    chk("irq_ack", 32'(irq), 32'd0);
`endif

    for (int t = 0; t < 10; t++) begin
      int dv, pr, ln;
      dv = $urandom_range(2, 0);
      pr = $urandom_range(7, 0);
      ln = $urandom_range(7, 0);
      for (int s = 0; s < 8; s++) duty_m[s] = $urandom_range(pr + 2, 0);
      run_seq(dv, pr, ln, h);
    end

    // asynchronous reset in the middle of a period
    wr(A_DIV, 32'd3);
    wr(A_PERIOD, 32'd4);
    wr(A_LEN, 32'd0);
    wr(A_IDX, 32'd0);
    wr(A_DATA, 32'd5);
    wr(A_CTRL, 32'd3);
    step1();
    step1();
    chk("arst_pre_pwm", 32'(pwm_out), 32'd1);
    chk("arst_pre_div", 32'(div_sel), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_div", 32'(div_sel), 32'd0);
    chk("arst_pulse", 32'(step_pulse), 32'd0);
    step1();
    reset_n = 1'b1;
    step1();
    chk("arst_after_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pwm_wave_sched.md
PWM_WAVE_SCHED -- requirements
Module: pwm_wave_sched

Interface
REQ-001 SHALL have parameter TBL_DEPTH, default 8, number of duty-table entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the PWM period and duty values.
REQ-003 SHALL have port clk, input, 1, the system clock. Reset reset_n is asynchronous and active-low; clock is clk.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port address, input, 3, the Avalon-MM slave word address.
REQ-006 SHALL have ports chipselect and write_n, inputs, 1 each; a write occurs when chipselect=1 and write_n=0.
REQ-007 SHALL have port writedata, input, 32, the write data.
REQ-008 SHALL have port readdata, output, 32, combinational read data with zero wait states.
REQ-009 SHALL have port div_sel, output, 3, the active prescaler select driven to external divider logic.
REQ-010 SHALL have ports pwm_out, busy and step_pulse, outputs, 1 each: the PWM wave, sequencer active, and a one-cycle pulse per completed PWM period.

Function
REQ-011 SHALL implement this register map: 0 CTRL{bit0 run, bit1 loop}; 1 DIV[2:0]; 2 PERIOD[CNT_W-1:0]; 3 LEN[log2 TBL_DEPTH-1:0], where the number of entries = LEN+1; 4 TBL_IDX write pointer; 5 TBL_DATA; 6 STATUS{bit0 busy, bits[7:4] cur_step} (read-only). Unused bits SHALL read as 0.
REQ-012 A write to TBL_DATA SHALL store duty[TBL_IDX] and post-increment TBL_IDX modulo TBL_DEPTH.
REQ-013 The FSM SHALL have the states IDLE, LOAD and RUN, with busy=1 in LOAD and RUN.
REQ-014 In IDLE, a write of run=1 at cycle N SHALL give LOAD at N+1, then RUN at N+2 with step=0 and both counters at 0.
REQ-015 LOAD SHALL copy DIV and PERIOD into shadow registers; div_sel SHALL always equal shadow DIV.
REQ-016 The prescaler SHALL tick once every 2^div_sel clk cycles, with the first tick on the last cycle of the first interval.
REQ-017 On each tick, the PWM counter SHALL advance 0..PERIOD, then wrap to 0; a wrap ends a PWM period.
REQ-018 pwm_out SHALL be registered and equal (cnt < duty[step]) while in RUN, and 0 otherwise.
REQ-019 If duty >= PERIOD+1, pwm_out SHALL stay high for the full period; if duty=0, it SHALL stay low.
REQ-020 At each period end, the block SHALL pulse step_pulse for one cycle and reload the shadow DIV/PERIOD registers; writes made mid-period SHALL take effect only at a period boundary.
REQ-021 At each period end, if step<LEN, step SHALL increment; if step=LEN and loop=1, step SHALL become 0; if step=LEN and loop=0, the FSM SHALL go to IDLE and clear run.
REQ-022 A write of run=0 in RUN or LOAD SHALL force IDLE on the next cycle, with pwm_out=0 and no step_pulse.
REQ-023 A write of run=1 while busy SHALL be ignored, with no restart; the loop bit SHALL still update.
REQ-024 Table writes during RUN SHALL be allowed; the new duty SHALL apply from the next cycle it is indexed.

Reset
REQ-025 Reset SHALL clear all registers, the duty table, counters and step; state SHALL be IDLE; pwm_out, busy, step_pulse and div_sel SHALL be 0.
REQ-026 Reset asserted mid-RUN SHALL take effect immediately and asynchronously, with no completion of the current period.

Configuration
REQ-027 The macro PWM_WAVE_SCHED_IRQ_EN, when defined, SHALL add output irq, plus IRQ register address 7{bit0 pending, bit1 enable}.
REQ-028 With the macro defined, pending SHALL set when the FSM leaves RUN because the sequence finished (REQ-021), and SHALL clear on a write of 1 to bit0; irq SHALL equal pending & enable.
REQ-029 Without the macro, there SHALL be no irq port, and address 7 SHALL read as 0.

Structure
REQ-030 The package pwm_wave_sched_pkg SHALL hold the register-address localparams, CTRL bit positions and the state enum type.
REQ-031 The prescaler (div_sel in, tick out, clear in) SHALL be sub-module pwm_prescaler; all other logic SHALL be in pwm_wave_sched.

Verification
REQ-032 Bench SHALL check: DIV=0, PERIOD=3, LEN=0, duty[0]=2, run=1 at N -> pwm_out high at N+2..N+3, low at N+4..N+5, step_pulse at N+5, repeat every 4 cycles.
REQ-033 Bench SHALL check: DIV=2, PERIOD=1, LEN=2, loop=0, duties {0,1,2} -> low 8, high 4/low 4, high 8 cycles; then busy=0, CTRL.run=0.
REQ-034 Bench SHALL check: PERIOD=9, a DIV write from 0 to 3 mid-period -> div_sel changes only in the cycle after step_pulse.
REQ-035 Bench SHALL check: a run=0 write while RUN with pwm_out=1 -> pwm_out=0 and busy=0 on the next cycle, and no step_pulse.
REQ-036 Bench SHALL check: TBL_IDX=7, two TBL_DATA writes -> duty[7], then duty[0] written; a TBL_IDX readback of 1.
REQ-037 Bench SHALL check: with IRQ_EN, enable=1, loop=0 sequence end -> irq=1; a write of 1 to IRQ bit0 -> irq=0 on the next cycle.
